fb_scanout: RTL and testbench

Framebuffer scan-out engine: reads a completed 256x256 frame back out of image memory and streams it as 24-bit RGB pixels with valid/ready flow control. The photo-album controller writes frames into image memory. This block is its reader: it owns the IM read port while a scan is active and feeds a downstream display/capture sink. Row-major raster order, one memory read per pixel, with a small FIFO absorbing the memory read latency and sink back-pressure.

---
 rtl/fb_scanout_if.sv | 26 ++
 rtl/fb_scanout.sv | 154 +++++++++++++++
 tb/tb_fb_scanout.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fb_scanout_if.sv
// Scan-out bundle: start/status, image-memory read port and pixel stream.
// The master side is the scan-out engine; the slave side is the memory plus sink.
interface fb_scanout_if;
   logic        start;
   logic [19:0] fb_base;
   logic        busy;
   logic [19:0] IM_A;
   logic        IM_WEN;
   logic [23:0] IM_Q;
   logic [23:0] PX_D;
   logic        PX_VALID;
   logic        PX_READY;
   logic        PX_SOF;
   logic        PX_EOL;
   logic        PX_EOF;

   modport master (
      input  start, fb_base, IM_Q, PX_READY,
      output busy, IM_A, IM_WEN, PX_D, PX_VALID, PX_SOF, PX_EOL, PX_EOF
   );

   modport slave (
      output start, fb_base, IM_Q, PX_READY,
      input  busy, IM_A, IM_WEN, PX_D, PX_VALID, PX_SOF, PX_EOL, PX_EOF
   );
endinterface

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: raster-order reads from image memory, one per pixel, streamed
// through a small FIFO as RGB pixels tagged with start-of-frame/end-of-line/end-of-frame.
module fb_scanout #(
   parameter int unsigned WIDTH      = 256,
   parameter int unsigned HEIGHT     = 256,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic          clk,
   input logic          reset,
   fb_scanout_if.master scan_io
);
   localparam int unsigned XW = $clog2(WIDTH);
   localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [XW-1:0] XMax   = XW'(WIDTH - 1);
   localparam logic [YW-1:0] YMax   = YW'(HEIGHT - 1);
   localparam logic [CW:0]   DepthC = (CW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } flags_t;

   typedef struct packed {
      logic [23:0] d;
      flags_t      f;
   } entry_t;

   state_e        state_q, state_d;
   logic [19:0]   base_q, base_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [19:0]   im_a_q, im_a_d;
   logic          a_vld_q, a_vld_d;   // address on IM_A this cycle
   flags_t        a_flg_q, a_flg_d;
   logic          q_vld_q;            // IM_Q carries read data this cycle
   flags_t        q_flg_q;

   entry_t        fifo_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;

   logic          issue, room, push, pop, last;
   logic [19:0]   ib;
   logic [XW-1:0] ix;
   logic [YW-1:0] iy;
   logic [CW:0]   occ;
   entry_t        head;

   assign head = fifo_q[rd_ptr_q];
   assign push = q_vld_q;
   assign pop  = (count_q != '0) && scan_io.PX_READY;
   // Both pipeline stages count against free space so the unconditional push never overflows.
   assign occ  = {1'b0, count_q} + {{CW{1'b0}}, a_vld_q} + {{CW{1'b0}}, q_vld_q};
   assign room = occ < DepthC;
   assign last = (ix == XMax) && (iy == YMax);

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      x_d     = x_q;
      y_d     = y_q;
      im_a_d  = im_a_q;
      a_vld_d = 1'b0;
      a_flg_d = a_flg_q;
      issue   = 1'b0;
      ib      = base_q;
      ix      = x_q;
      iy      = y_q;
      unique case (state_q)
         StIdle: begin
            if (scan_io.start) begin
               issue   = 1'b1;
               ib      = scan_io.fb_base;
               ix      = '0;
               iy      = '0;
               base_d  = scan_io.fb_base;
               state_d = StFetch;
            end
         end
         StFetch: issue = room;
         StDrain: begin
            if (pop && head.f.eof) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (issue) begin
         im_a_d      = ib + 20'({iy, ix});
         a_vld_d     = 1'b1;
         a_flg_d.sof = (ix == '0) && (iy == '0);
         a_flg_d.eol = (ix == XMax);
         a_flg_d.eof = last;
         if (ix == XMax) begin
            x_d = '0;
            y_d = iy + 1'b1;
         end else begin
            x_d = ix + 1'b1;
            y_d = iy;
         end
         if (last) state_d = StDrain;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         base_q   <= '0;
         x_q      <= '0;
         y_q      <= '0;
         im_a_q   <= '0;
         a_vld_q  <= 1'b0;
         a_flg_q  <= '0;
         q_vld_q  <= 1'b0;
         q_flg_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         x_q     <= x_d;
         y_q     <= y_d;
         im_a_q  <= im_a_d;
         a_vld_q <= a_vld_d;
         a_flg_q <= a_flg_d;
         q_vld_q <= a_vld_q;
         q_flg_q <= a_flg_q;
         if (push) begin
            fifo_q[wr_ptr_q] <= '{d: scan_io.IM_Q, f: q_flg_q};
            wr_ptr_q         <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign scan_io.IM_A     = im_a_q;
   assign scan_io.IM_WEN   = 1'b1;
   assign scan_io.busy     = (state_q != StIdle);
   assign scan_io.PX_VALID = (count_q != '0);
   assign scan_io.PX_D     = head.d;
   assign scan_io.PX_SOF   = head.f.sof;
   assign scan_io.PX_EOL   = head.f.eol;
   assign scan_io.PX_EOF   = head.f.eof;
endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout on a reduced 16x16 frame: random sink back-pressure against a
// model of the expected raster stream, address sequence and FIFO occupancy bound.
module tb_fb_scanout;
   localparam int W = 16;
   localparam int H = 16;
   localparam int N = W * H;
   localparam int D = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   nchk = 0;
   int   nfail = 0;
   logic [19:0] a128;

   fb_scanout_if bus ();

   fb_scanout #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
      .clk    (clk),
      .reset  (reset),
      .scan_io(bus)
   );

   always #5 clk = ~clk;

   // Memory contents are a fixed function of address so every word is distinguishable.
   function automatic logic [23:0] mword(input logic [19:0] a);
      return {a[3:0], a};
   endfunction

   always @(posedge clk) bus.IM_Q <= mword(bus.IM_A);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_im_a"}, 32'(bus.IM_A), 32'd0);
      chk({tag, "_im_wen"}, 32'(bus.IM_WEN), 32'd1);
      chk({tag, "_px_d"}, 32'(bus.PX_D), 32'd0);
      chk({tag, "_px_valid"}, 32'(bus.PX_VALID), 32'd0);
      chk({tag, "_flags"}, 32'({bus.PX_SOF, bus.PX_EOL, bus.PX_EOF}), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   // One frame from a start pulse. reset_at >= 0 stalls the sink once that many pixels
   // have transferred, lets the FIFO fill, then aborts the scan with an async reset.
   task automatic run_frame(input logic [19:0] base, input int unsigned pct,
                            input int reset_at, input bit mid_start);
      int          k = 0;
      int          issued = 1;
      int          cyc = 0;
      int          busy_cyc = 0;
      int          hold = 0;
      bit          first_seen = 0;
      bit          stalled = 0;
      bit          done = 0;
      bit          rdy;
      logic [19:0] prev_a;
      logic [19:0] ea;
      logic [2:0]  ef;

      @(negedge clk);
      bus.start   = 1'b1;
      bus.fb_base = base;
      bus.PX_READY = 1'b0;
      @(negedge clk);
      bus.start   = 1'b0;
      bus.fb_base = 20'h0;
      chk("e0_busy", 32'(bus.busy), 32'd1);
      chk("e0_im_a", 32'(bus.IM_A), 32'(base));
      chk("e0_valid", 32'(bus.PX_VALID), 32'd0);
      prev_a = bus.IM_A;

      while (!done && cyc < 40 * N) begin
         if (bus.busy) busy_cyc++;
         if (cyc > 0 && bus.IM_A !== prev_a) begin
            ea = base + 20'(issued);
            chk("issue_addr", 32'(bus.IM_A), 32'(ea));
            if (issued == 128) a128 = bus.IM_A;
            issued++;
            prev_a = bus.IM_A;
         end
         chk("outstanding_le_depth", 32'(issued - k <= D), 32'd1);
         chk("im_wen", 32'(bus.IM_WEN), 32'd1);
         if (stalled) chk("valid_held", 32'(bus.PX_VALID), 32'd1);
         if (pct == 100 && k > 0 && k < N) chk("no_bubble", 32'(bus.PX_VALID), 32'd1);
         if (bus.PX_VALID) begin
            if (!first_seen) begin
               first_seen = 1;
               chk("first_valid_cycle", 32'(cyc), 32'd2);
            end
            ea = base + 20'(k);
            ef = {k == 0, (k % W) == W - 1, k == N - 1};
            chk("px_d", 32'(bus.PX_D), 32'(mword(ea)));
            chk("px_flags", 32'({bus.PX_SOF, bus.PX_EOL, bus.PX_EOF}), 32'(ef));
         end
         if (!bus.busy && k == N) begin
            done = 1;
         end else begin
            if (reset_at >= 0 && k >= reset_at) begin
               rdy = 1'b0;
               hold++;
               if (hold > 8) begin
                  chk("fifo_full_pre_reset", 32'(issued - k), 32'(D));
                  chk("valid_pre_reset", 32'(bus.PX_VALID), 32'd1);
                  #2 reset = 1'b1;
                  #1 chk_reset_vals("abort");
                  @(negedge clk);
                  chk_reset_vals("abort_held");
                  reset = 1'b0;
                  return;
               end
            end else begin
               rdy = ($urandom_range(99) < pct);
            end
            bus.PX_READY = rdy;
            stalled = bus.PX_VALID && !rdy;
            if (bus.PX_VALID && rdy) k++;
            if (mid_start && cyc == 50) begin
               bus.start   = 1'b1;
               bus.fb_base = 20'h55555;
            end else begin
               bus.start   = 1'b0;
               bus.fb_base = 20'h0;
            end
            cyc++;
            @(negedge clk);
         end
      end
      chk("frame_done", 32'(done), 32'd1);
      chk("pixel_count", 32'(k), 32'(N));
      chk("issue_count", 32'(issued), 32'(N));
      if (pct == 100) chk("busy_cycles", 32'(busy_cyc), 32'(N + 2));
      chk("valid_after_frame", 32'(bus.PX_VALID), 32'd0);
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.fb_base  = 20'h0;
      bus.PX_READY = 1'b0;
      a128         = 20'hABCDE;
      #1 chk_reset_vals("por");
      @(negedge clk);
      chk_reset_vals("por_clk");
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 32'd0);

      run_frame(20'h10000, 100, -1, 1'b0);   // basic frame, full rate
      run_frame(20'h23456, 30, -1, 1'b1);    // back-pressure, ignored mid-frame start
      a128 = 20'hABCDE;
      run_frame(20'hFFF80, 100, -1, 1'b0);   // address wrap, immediate restart
      chk("wrap_addr128", 32'(a128), 32'd0);
      run_frame(20'h00400, 100, 100, 1'b0);  // reset with full FIFO
      run_frame(20'h00400, 50, -1, 1'b0);    // clean frame after abort

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
